// File: rtl/sevenseg_scanner_if.sv
// Bundle of control inputs and display outputs for the seven-segment scanner.
// The CSR side uses the master view and the scanner uses the slave view.
interface sevenseg_scanner_if #(
  parameter int NUM_DIGITS   = 4,
  parameter int PERIOD_WIDTH = 24,
  parameter int BRIGHT_WIDTH = 4
);
  localparam int IDX_WIDTH = $clog2(NUM_DIGITS);

  logic                      ENABLE;
  logic                      MODE;
  logic [8*NUM_DIGITS-1:0]   DIGITS_IN;
  logic [NUM_DIGITS-1:0]     BLANK_MASK;
  logic [PERIOD_WIDTH-1:0]   PERIOD;
  logic [BRIGHT_WIDTH-1:0]   BRIGHTNESS;
  logic [NUM_DIGITS-1:0]     ANODES;
  logic [7:0]                SEGMENTS;
  logic [IDX_WIDTH-1:0]      DIGIT_IDX;
  logic                      FRAME_DONE;

  modport master (
    output ENABLE, MODE, DIGITS_IN, BLANK_MASK, PERIOD, BRIGHTNESS,
    input  ANODES, SEGMENTS, DIGIT_IDX, FRAME_DONE
  );

  modport slave (
    input  ENABLE, MODE, DIGITS_IN, BLANK_MASK, PERIOD, BRIGHTNESS,
    output ANODES, SEGMENTS, DIGIT_IDX, FRAME_DONE
  );
endinterface

// File: rtl/sevenseg_scanner.sv
// N-digit seven-segment scanner: walks a dwell counter across the digits,
// decodes the selected byte (hex or raw), gates it with PWM brightness and
// per-digit blanking, and registers polarity-adjusted anode/segment pins.
module sevenseg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int PERIOD_WIDTH = 24,
  parameter int BRIGHT_WIDTH = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic               CLK,
  input logic               RSTN,
  sevenseg_scanner_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]            SEG_POL  = {8{ACTIVE_LOW}};

  logic [IW-1:0]           idx;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [BRIGHT_WIDTH-1:0] pwm;
  logic                    wrap_q;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [7:0]              seg_q;
  logic [IW-1:0]           didx_q;
  logic                    fd_q;

  logic [7:0]              digit_byte;
  logic [6:0]              hex_seg;
  logic [7:0]              seg_logic;
  logic                    pwm_on;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [7:0]              seg_next;

  // Select and decode the current digit, then gate it with enable/PWM/blank.
  always_comb begin
    digit_byte = bus.DIGITS_IN[{idx, 3'b000} +: 8];
    hex_seg    = 7'h00;
    case (digit_byte[3:0])
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
    seg_logic = bus.MODE ? {digit_byte[7], hex_seg} : digit_byte;
    pwm_on    = (bus.BRIGHTNESS == '1) || (pwm < bus.BRIGHTNESS);
    lit       = bus.ENABLE && pwm_on && !bus.BLANK_MASK[idx];
    an_onehot      = '0;
    an_onehot[idx] = 1'b1;
    an_next   = lit ? an_onehot : '0;
    seg_next  = lit ? seg_logic : '0;
  end

  // Dwell counter, digit index and PWM counter; all cleared while disabled.
  // wrap_q remembers an N-1 -> 0 wrap so FRAME_DONE lines up with the pins.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      idx    <= '0;
      cnt    <= '0;
      pwm    <= '0;
      wrap_q <= 1'b0;
    end else if (!bus.ENABLE) begin
      idx    <= '0;
      cnt    <= '0;
      pwm    <= '0;
      wrap_q <= 1'b0;
    end else begin
      pwm <= pwm + 1'b1;
      if (cnt == '0) begin
        cnt    <= bus.PERIOD;
        idx    <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        wrap_q <= (idx == LAST_IDX);
      end else begin
        cnt    <= cnt - 1'b1;
        wrap_q <= 1'b0;
      end
    end
  end

  // Registered pins with polarity applied last.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      an_q   <= AN_POL;
      seg_q  <= SEG_POL;
      didx_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      an_q   <= an_next ^ AN_POL;
      seg_q  <= seg_next ^ SEG_POL;
      didx_q <= bus.ENABLE ? idx : '0;
      fd_q   <= bus.ENABLE && wrap_q;
    end
  end

  assign bus.ANODES     = an_q;
  assign bus.SEGMENTS   = seg_q;
  assign bus.DIGIT_IDX  = didx_q;
  assign bus.FRAME_DONE = fd_q;
endmodule
